// File: rtl/mem_resp_pkg.sv
// rtl/mem_resp_pkg.sv - shared response codes and FSM state type for the read responder
package mem_resp_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/mem_read_responder_if.sv
// rtl/mem_read_responder_if.sv - read request/response channels plus array write port
// master: drives arvalid/araddr, rready, wen/waddr/wdata
// slave : drives arready, rvalid/rdata/rresp
interface mem_read_responder_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              arvalid;
    logic              arready;
    logic [ADDR_W-1:0] araddr;
    logic              rvalid;
    logic              rready;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              wen;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;

    modport master (
        output arvalid, araddr, rready, wen, waddr, wdata,
        input  arready, rvalid, rdata, rresp
    );

    modport slave (
        input  arvalid, araddr, rready, wen, waddr, wdata,
        output arready, rvalid, rdata, rresp
    );
endinterface

// File: rtl/resp_word_array.sv
// rtl/resp_word_array.sv - DEPTH x DATA_W word store, sync write, registered read
// clk            : clock
// we/waddr/wdata : word write, applied at the clock edge
// re/raddr       : read strobe and index; rdata holds its value while re is low
// rdata          : registered read data (old contents on a same-edge write)
module resp_word_array #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 1024,
    parameter int IDX_W  = 10
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IDX_W-1:0]  waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [IDX_W-1:0]  raddr,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;
    logic [DATA_W-1:0] rdata_d;

    // Holding the output register when not reading keeps a captured word
    // immune to later writes of the same index.
    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = mem_q[raddr];
        end
    end

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
        rdata_q <= rdata_d;
    end

    assign rdata = rdata_q;
endmodule

// File: rtl/mem_read_responder.sv
// rtl/mem_read_responder.sv - one-at-a-time fixed-latency word read responder
// clk : clock
// rst : synchronous active-high reset
// bus : slave side of mem_read_responder_if (read request, response, write port)
module mem_read_responder
    import mem_resp_pkg::*;
#(
    parameter int              ADDR_W  = 32,
    parameter int              DATA_W  = 32,
    parameter int              DEPTH   = 1024,
    parameter int              LATENCY = 1,
    parameter logic [ADDR_W-1:0] BASE  = 32'h8000_0000
) (
    input logic                 clk,
    input logic                 rst,
    mem_read_responder_if.slave bus
);
    localparam int BYTES     = DATA_W / 8;
    localparam int OFF_SHIFT = $clog2(BYTES);
    localparam int IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // Span is compared one bit wider so BASE+span may reach the top of the
    // address space without wrapping.
    localparam logic [ADDR_W:0] SPAN = (ADDR_W+1)'(DEPTH * BYTES);

    function automatic logic addr_hit(input logic [ADDR_W-1:0] a);
        logic [ADDR_W-1:0] off;
        off = a - BASE;
        return (a >= BASE) && ({1'b0, off} < SPAN);
    endfunction

    function automatic logic [IDX_W-1:0] addr_idx(input logic [ADDR_W-1:0] a);
        return IDX_W'((a - BASE) >> OFF_SHIFT);
    endfunction

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              arready_q, arready_d;
    logic              decerr_q, decerr_d;

    logic              accept;
    logic              rd_hit;
    logic              wr_hit;
    logic [IDX_W-1:0]  rd_idx;
    logic [IDX_W-1:0]  wr_idx;
    logic [DATA_W-1:0] arr_rdata;

    assign rd_hit = addr_hit(bus.araddr);
    assign wr_hit = addr_hit(bus.waddr);
    assign rd_idx = addr_idx(bus.araddr);
    assign wr_idx = addr_idx(bus.waddr);
    assign accept = arready_q && bus.arvalid;

    resp_word_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_array (
        .clk   (clk),
        .we    (bus.wen && wr_hit),
        .waddr (wr_idx),
        .wdata (bus.wdata),
        .re    (accept && rd_hit),
        .raddr (rd_idx),
        .rdata (arr_rdata)
    );

    // arready is a flop so it stays low through reset and only rises once
    // the register has seen rst low.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            arready_q <= 1'b0;
            decerr_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            arready_q <= arready_d;
            decerr_q  <= decerr_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        decerr_d = decerr_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    decerr_d = !rd_hit;
                    if (LATENCY == 1) begin
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = 4'(LATENCY - 2);
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (bus.rready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        arready_d = (state_d == IDLE);
    end

    // Response data is gated by state so nothing stale leaks outside RESP.
    always_comb begin
        bus.arready = arready_q;
        bus.rvalid  = (state_q == RESP);
        bus.rdata   = '0;
        bus.rresp   = RESP_OKAY;
        if (state_q == RESP) begin
            if (decerr_q) begin
                bus.rresp = RESP_DECERR;
            end else begin
                bus.rdata = arr_rdata;
            end
        end
    end
endmodule

// File: doc/mem_read_responder.md
# mem_read_responder

Memory-side read responder: accepts one read request at a time over a valid/ready address channel, waits a fixed number of cycles, then returns a data word over a valid/ready response channel. It sits behind the core's load path and serves word reads from an internal array. A simple write port preloads the array or updates it at run time.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width; a power of two, 8 or more
- DEPTH, 1024, number of words in the array
- LATENCY, 1, cycles from request acceptance to `rvalid`; legal range 1..15
- BASE, 32'h8000_0000, byte address of word 0
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- arvalid  in  1  read request valid
- arready  out  1  responder can accept a request
- araddr  in  ADDR_W  read byte address
- rvalid  out  1  response valid
- rready  in  1  requester accepts the response
- rdata  out  DATA_W  read data
- rresp  out  2  response code: 2'b00 OKAY, 2'b11 DECERR
- wen  in  1  array write enable
- waddr  in  ADDR_W  write byte address
- wdata  in  DATA_W  write data

## Operation
- FSM states are IDLE, WAIT and RESP. Reset state is IDLE.
- IDLE:
  - `arready`=1.
  - On `arvalid&&arready`: decode `araddr` and snapshot the array word (or error) into the response registers.
  - Go to RESP if LATENCY==1; otherwise go to WAIT with the counter loaded to LATENCY-2.
- WAIT:
  - `arready`=0 and `rvalid`=0.
  - Counter decrements each cycle.
  - Go to RESP on the cycle the counter reads 0.
- RESP:
  - `rvalid`=1; `rdata` and `rresp` are held stable.
  - On `rvalid&&rready`: go to IDLE. `rready` low means stay indefinitely.
- Decode:
  - A read is in range when BASE <= araddr < BASE+DEPTH*(DATA_W/8).
  - Index is (araddr-BASE)>>log2(DATA_W/8). Low byte-offset bits are ignored.
  - Out-of-range read: `rresp`=2'b11, `rdata`=0.
- Write port:
  - Independent of the FSM.
  - When `wen` is high and `waddr` is in range, the word is written at the clock edge. An out-of-range write is silently dropped.
- Read/write collisions:
  - A write to the same index in the acceptance cycle is not visible: read-before-write.
  - Writes after acceptance never alter a pending response.
- Reset:
  - The array contents are not reset.
  - `rst` asserted in any state returns to IDLE next edge; a pending response is discarded and no `rvalid` appears.

## Timing
- Outputs are driven from state/registers only; there is no combinational path from inputs to outputs.
- Reset values:
  - During `rst`: `arready`=0, `rvalid`=0, `rdata`=0, `rresp`=2'b00.
  - `arready`=1 from the first cycle after `rst` deasserts.
- Request handshake in cycle T gives `rvalid` high from cycle T+LATENCY.
- Response handshake in cycle R gives `arready` high in cycle R+1. No request is accepted in the same cycle as a response.
- Peak throughput is one read per LATENCY+1 cycles.
- `arvalid` held across a busy period is accepted on the first IDLE cycle.

## Structure
- Shared package `mem_resp_pkg`:
  - response code constants RESP_OKAY and RESP_DECERR
  - FSM state enum {IDLE, WAIT, RESP}
- Sub-module `resp_word_array`:
  - DEPTH x DATA_W storage
  - one synchronous write port and one read port with registered output
  - no reset on the contents
- The FSM, counter, decode and response registers live in the top module.

## Test plan
- Reset: hold `rst` 3 cycles → `arready`=0 and `rvalid`=0 throughout; `arready`=1 on the first cycle after release.
- Basic read, LATENCY=1:
  - Stimulus: write 32'hDEAD_BEEF to 32'h8000_0010, then read 32'h8000_0013 in cycle T with `rready`=1.
  - Required: `rvalid` in T+1, `rdata`=32'hDEAD_BEEF, `rresp`=00; `arready` back in T+2.
- Latency and backpressure, LATENCY=4:
  - Stimulus: read in cycle T; hold `rready`=0 for 5 cycles.
  - Required: `rvalid` rises in T+4 and stays high with stable data until `rready` is raised.
- Decode error: read 32'h7FFF_FFFC and 32'h8000_1000 (DEPTH=1024) → `rresp`=2'b11, `rdata`=0 for each.
- Write collisions:
  - Stimulus: word 32'h8000_0020 holds 32'h1111_1111. In the acceptance cycle write 32'h2222_2222 to it, and write 32'h3333_3333 during WAIT.
  - Required: `rdata`=32'h1111_1111; the following read returns 32'h3333_3333.
- Mid-operation reset: assert `rst` in WAIT (LATENCY=4) → no `rvalid` ever appears for that request; a new read completes normally afterward.
